// File: rtl/tag_bank_ctrl_pkg.sv
// Shared types for the tag bank controller: FSM state encoding and the bank entry layout.
package tag_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_t;

    localparam int TAG_W_DEFAULT = 20;

    // Reference layout of one bank entry; the controller packs entries as {valid, tag}.
    typedef struct packed {
        logic                     valid;
        logic [TAG_W_DEFAULT-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/tag_bank_ctrl_bank.sv
// Simple dual-port tag memory: port A registered read, port B write.
module tag_bank #(
    parameter int WIDTH = 21,
    parameter int LINES = 512
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(LINES)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data
);

    logic [WIDTH-1:0] mem [LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first: a same-cycle write to rd_addr is not visible here.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tag_bank_ctrl.sv
// Tag bank controller: pipelined single-cycle lookups on port A, fills/invalidates/sweeps on port B.
module tag_bank_ctrl
    import tag_bank_ctrl_pkg::*;
#(
    parameter int LINES = 512,
    parameter int TAG_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_req,
    input  logic [$clog2(LINES)-1:0] lookup_line,
    input  logic [TAG_W-1:0]         lookup_tag,
    output logic                     lookup_ready,
    output logic                     result_valid,
    output logic                     hit,
    input  logic                     fill_req,
    input  logic [$clog2(LINES)-1:0] fill_line,
    input  logic [TAG_W-1:0]         fill_tag,
    output logic                     fill_ack,
    input  logic                     inv_req,
    input  logic [$clog2(LINES)-1:0] inv_line,
    output logic                     inv_ack,
    input  logic                     flush_req,
    output logic                     busy,
    output logic                     flush_done
);

    localparam int LINE_W = $clog2(LINES);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    ctrl_state_t       state_reg;
    logic [LINE_W-1:0] sweep_cnt_reg;
    logic              flush_pend_reg;
    logic              flush_done_reg;
    logic              result_valid_reg;
    logic              bypass_sel_reg;
    logic [TAG_W-1:0]  lookup_tag_reg;
    logic [TAG_W:0]    bypass_entry_reg;
    logic [TAG_W:0]    rd_entry;
    logic [TAG_W:0]    cmp_entry;

    logic              idle;
    logic              accept;
    logic              b_we;
    logic [LINE_W-1:0] b_addr;
    logic [TAG_W:0]    b_wdata;

    assign idle         = (state_reg == ST_IDLE);
    assign lookup_ready = idle;
    assign busy         = ~idle;
    assign fill_ack     = fill_req & idle;
    assign inv_ack      = inv_req & ~fill_req & idle;
    assign accept       = lookup_req & idle;
    assign flush_done   = flush_done_reg;
    assign result_valid = result_valid_reg;

    // Port B owner: the sweep whenever not idle, otherwise fill over invalidate.
    always_comb begin
        b_we    = 1'b0;
        b_addr  = sweep_cnt_reg;
        b_wdata = '0;
        if (!idle) begin
            b_we = 1'b1;
        end else if (fill_req) begin
            b_we    = 1'b1;
            b_addr  = fill_line;
            b_wdata = {1'b1, fill_tag};
        end else if (inv_req) begin
            b_we   = 1'b1;
            b_addr = inv_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            sweep_cnt_reg  <= '0;
            flush_pend_reg <= 1'b0;
            flush_done_reg <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_reg     <= ST_FLUSH;
                        sweep_cnt_reg <= '0;
                    end
                end
                default: begin
                    if (sweep_cnt_reg == LAST_LINE) begin
                        sweep_cnt_reg  <= '0;
                        flush_done_reg <= (state_reg == ST_FLUSH);
                        if (flush_pend_reg || flush_req) begin
                            state_reg      <= ST_FLUSH;
                            flush_pend_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
                        if (flush_req) begin
                            flush_pend_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // A port B write to the line being looked up wins over the read-first bank data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_reg <= 1'b0;
            bypass_sel_reg   <= 1'b0;
            lookup_tag_reg   <= '0;
            bypass_entry_reg <= '0;
        end else begin
            result_valid_reg <= accept;
            bypass_sel_reg   <= accept & b_we & (b_addr == lookup_line);
            lookup_tag_reg   <= lookup_tag;
            bypass_entry_reg <= b_wdata;
        end
    end

    assign cmp_entry = bypass_sel_reg ? bypass_entry_reg : rd_entry;
    assign hit       = result_valid_reg & cmp_entry[TAG_W] & (cmp_entry[TAG_W-1:0] == lookup_tag_reg);

    tag_bank #(
        .WIDTH (TAG_W + 1),
        .LINES (LINES)
    ) u_tag_bank (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (lookup_line),
        .rd_data (rd_entry),
        .wr_en   (b_we),
        .wr_addr (b_addr),
        .wr_data (b_wdata)
    );

endmodule

// File: tb/tb_tag_bank_ctrl.sv
// Bench for tag_bank_ctrl (LINES=16): directed vectors, a cycle-level reference model and literal pins.
module tb_tag_bank_ctrl;

    localparam int LINES = 16;
    localparam int TAG_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lookup_req = 1'b0;
    logic [3:0]       lookup_line = '0;
    logic [TAG_W-1:0] lookup_tag = '0;
    logic             lookup_ready;
    logic             result_valid;
    logic             hit;
    logic             fill_req = 1'b0;
    logic [3:0]       fill_line = '0;
    logic [TAG_W-1:0] fill_tag = '0;
    logic             fill_ack;
    logic             inv_req = 1'b0;
    logic [3:0]       inv_line = '0;
    logic             inv_ack;
    logic             flush_req = 1'b0;
    logic             busy;
    logic             flush_done;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    tag_bank_ctrl #(.LINES(LINES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_req   (lookup_req),
        .lookup_line  (lookup_line),
        .lookup_tag   (lookup_tag),
        .lookup_ready (lookup_ready),
        .result_valid (result_valid),
        .hit          (hit),
        .fill_req     (fill_req),
        .fill_line    (fill_line),
        .fill_tag     (fill_tag),
        .fill_ack     (fill_ack),
        .inv_req      (inv_req),
        .inv_line     (inv_line),
        .inv_ack      (inv_ack),
        .flush_req    (flush_req),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sweep remaining-cycle countdown, pending flag, and bank contents.
    int              m_left = 16;
    bit              m_is_flush = 1'b0;
    bit              m_pend = 1'b0;
    bit              m_rv = 1'b0;
    bit              m_hit = 1'b0;
    bit              m_fd = 1'b0;
    bit              m_valid [LINES];
    logic [TAG_W-1:0] m_tag  [LINES];

    function automatic bit predict_hit();
        if (fill_req && fill_line == lookup_line) return fill_tag == lookup_tag;
        if (!fill_req && inv_req && inv_line == lookup_line) return 1'b0;
        return m_valid[lookup_line] && (m_tag[lookup_line] == lookup_tag);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left     <= LINES;
            m_is_flush <= 1'b0;
            m_pend     <= 1'b0;
            m_rv       <= 1'b0;
            m_hit      <= 1'b0;
            m_fd       <= 1'b0;
        end else begin
            m_rv  <= lookup_req && (m_left == 0);
            m_hit <= (lookup_req && (m_left == 0)) ? predict_hit() : 1'b0;
            m_fd  <= 1'b0;
            if (m_left == 0) begin
                if (fill_req) begin
                    m_valid[fill_line] <= 1'b1;
                    m_tag[fill_line]   <= fill_tag;
                end else if (inv_req) begin
                    m_valid[inv_line] <= 1'b0;
                end
                if (flush_req) begin
                    m_left     <= LINES;
                    m_is_flush <= 1'b1;
                end
            end else if (m_left == 1) begin
                for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
                m_fd <= m_is_flush;
                if (m_pend || flush_req) begin
                    m_left     <= LINES;
                    m_is_flush <= 1'b1;
                    m_pend     <= 1'b0;
                end else begin
                    m_left <= 0;
                end
            end else begin
                m_left <= m_left - 1;
                if (flush_req) m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("model_lookup_ready", lookup_ready, m_left == 0);
            chk("model_busy", busy, m_left != 0);
            chk("model_fill_ack", fill_ack, fill_req && m_left == 0);
            chk("model_inv_ack", inv_ack, inv_req && !fill_req && m_left == 0);
            chk("model_result_valid", result_valid, m_rv);
            chk("model_hit", hit, m_rv && m_hit);
            chk("model_flush_done", flush_done, m_fd);
        end
    end

    task automatic fill(input logic [3:0] line, input logic [TAG_W-1:0] tag);
        @(posedge clk); #1;
        fill_req = 1'b1; fill_line = line; fill_tag = tag;
        @(negedge clk);
        chk("fill_ack", fill_ack, 1'b1);
        @(posedge clk); #1;
        fill_req = 1'b0;
        $display("fill line=%0d tag=%h", line, tag);
    endtask

    task automatic lookup_chk(input logic [3:0] line, input logic [TAG_W-1:0] tag, input logic exp_hit);
        @(posedge clk); #1;
        lookup_req = 1'b1; lookup_line = line; lookup_tag = tag;
        @(posedge clk); #1;
        lookup_req = 1'b0;
        @(negedge clk);
        chk("lookup_result_valid", result_valid, 1'b1);
        chk("lookup_hit", hit, exp_hit);
        $display("lookup line=%0d tag=%h hit=%b expect=%b", line, tag, hit, exp_hit);
    endtask

    // Samples n negedges; drives a one-cycle flush_req after sample pulse_at.
    task automatic count_window(input int n, input int pulse_at, output int busy_n,
                                output int fd_n, output logic rv0, output logic hit0);
        busy_n = 0; fd_n = 0; rv0 = 1'b0; hit0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin rv0 = result_valid; hit0 = hit; end
            if (busy) busy_n++;
            if (flush_done) fd_n++;
            flush_req = (i == pulse_at);
        end
        flush_req = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int bn, fdn;
        logic rv0, h0;

        // Reset held: acks must stay low even with requests present.
        fill_req = 1'b1; inv_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", lookup_ready, 1'b0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_fill_ack", fill_ack, 1'b0);
        chk("rst_inv_ack", inv_ack, 1'b0);
        fill_req = 1'b0; inv_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_en = 1'b1;

        count_window(24, -1, bn, fdn, rv0, h0);
        chk_int("init_busy_cycles", bn, 16);
        chk_int("init_flush_done_pulses", fdn, 0);
        $display("init busy_cycles=%0d flush_done=%0d", bn, fdn);
        lookup_chk(4'd9, 20'h00000, 1'b0);
        lookup_chk(4'd9, 20'hFFFFF, 1'b0);

        fill(4'd5, 20'h01234);
        lookup_chk(4'd5, 20'h01234, 1'b1);
        lookup_chk(4'd5, 20'h01235, 1'b0);

        // Fill beats invalidate; invalidate lands the following cycle.
        @(posedge clk); #1;
        fill_req = 1'b1; fill_line = 4'd7; fill_tag = 20'h000AA;
        inv_req = 1'b1; inv_line = 4'd7;
        @(negedge clk);
        chk("prio_fill_ack", fill_ack, 1'b1);
        chk("prio_inv_ack", inv_ack, 1'b0);
        @(posedge clk); #1;
        fill_req = 1'b0;
        @(negedge clk);
        chk("prio_inv_ack_next", inv_ack, 1'b1);
        @(posedge clk); #1;
        inv_req = 1'b0;
        $display("fill+inv line=7 fill_ack then inv_ack");
        lookup_chk(4'd7, 20'h000AA, 1'b0);

        // Same-cycle collisions must see the new entry.
        @(posedge clk); #1;
        fill_req = 1'b1; fill_line = 4'd3; fill_tag = 20'h00055;
        lookup_req = 1'b1; lookup_line = 4'd3; lookup_tag = 20'h00055;
        @(posedge clk); #1;
        fill_req = 1'b0; lookup_req = 1'b0;
        @(negedge clk);
        chk("bypass_fill_valid", result_valid, 1'b1);
        chk("bypass_fill_hit", hit, 1'b1);
        $display("bypass fill line=3 hit=%b", hit);
        lookup_chk(4'd3, 20'h00055, 1'b1);
        @(posedge clk); #1;
        inv_req = 1'b1; inv_line = 4'd3;
        lookup_req = 1'b1; lookup_line = 4'd3; lookup_tag = 20'h00055;
        @(posedge clk); #1;
        inv_req = 1'b0; lookup_req = 1'b0;
        @(negedge clk);
        chk("bypass_inv_hit", hit, 1'b0);
        $display("bypass inv line=3 hit=%b", hit);

        // Back-to-back lookups, one per cycle.
        fill(4'd1, 20'h00011);
        fill(4'd2, 20'h00022);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            lookup_req = 1'b1;
            lookup_line = (k % 2 == 0) ? 4'd1 : 4'd2;
            lookup_tag = (k == 0) ? 20'h00011 : 20'h00022;
            $display("pipelined lookup line=%0d tag=%h", lookup_line, lookup_tag);
        end
        @(posedge clk); #1;
        lookup_req = 1'b0;

        // Flush with a second request queued mid-sweep; lookup in last idle cycle.
        for (int i = 0; i < LINES; i++) fill(4'(i), 20'h00100 + 20'(i));
        @(posedge clk); #1;
        flush_req = 1'b1;
        lookup_req = 1'b1; lookup_line = 4'd2; lookup_tag = 20'h00102;
        @(posedge clk); #1;
        flush_req = 1'b0; lookup_req = 1'b0;
        count_window(40, 4, bn, fdn, rv0, h0);
        chk("flush_edge_result_valid", rv0, 1'b1);
        chk("flush_edge_hit", h0, 1'b1);
        chk_int("flush_busy_cycles", bn, 32);
        chk_int("flush_done_pulses", fdn, 2);
        $display("double flush busy_cycles=%0d flush_done=%0d", bn, fdn);
        for (int i = 0; i < LINES; i++) lookup_chk(4'(i), 20'h00100 + 20'(i), 1'b0);

        // Reset mid-sweep with a flush pending.
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_ready", lookup_ready, 1'b0);
        chk("midrst_flush_done", flush_done, 1'b0);
        chk("midrst_result_valid", result_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_window(24, -1, bn, fdn, rv0, h0);
        chk_int("reinit_busy_cycles", bn, 16);
        chk_int("reinit_flush_done_pulses", fdn, 0);
        $display("reinit busy_cycles=%0d flush_done=%0d", bn, fdn);
        lookup_chk(4'd5, 20'h00105, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_bank_ctrl.md
TAG_BANK_CTRL -- requirements
Module: tag_bank_ctrl

Interface
REQ-001 Parameter LINES, default 512, number of tag lines (power of two, >=2).
REQ-002 Parameter TAG_W, default 20, stored tag width; bank entry = {valid, tag}, TAG_W+1 bits.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 lookup_req  input  1  lookup request, accepted when lookup_ready=1.
REQ-006 lookup_line  input  $clog2(LINES)  line index for lookup.
REQ-007 lookup_tag  input  TAG_W  tag compared against the stored entry.
REQ-008 lookup_ready  output  1  lookup port can accept.
REQ-009 result_valid  output  1  one-cycle pulse, hit result valid.
REQ-010 hit  output  1  stored valid=1 and stored tag == lookup_tag; qualified by result_valid.
REQ-011 fill_req / fill_line / fill_tag  input  1 / $clog2(LINES) / TAG_W  write {1,fill_tag} to fill_line.
REQ-012 fill_ack  output  1  fill written this cycle.
REQ-013 inv_req / inv_line  input  1 / $clog2(LINES)  write {0,0} to inv_line.
REQ-014 inv_ack  output  1  invalidate written this cycle.
REQ-015 flush_req  input  1  request full invalidation sweep.
REQ-016 busy  output  1  INIT or FLUSH sweep in progress.
REQ-017 flush_done  output  1  one-cycle pulse after final sweep write.

Function
REQ-018 Port A of the tag bank SHALL serve lookups only (read); port B SHALL serve fill, invalidate and sweep writes only.
REQ-019 FSM states INIT, IDLE, FLUSH; rst -> INIT; INIT -> IDLE after last line; IDLE -> FLUSH on flush_req; FLUSH -> IDLE after last line.
REQ-020 Sweep: counter from 0 to LINES-1, one {0,0} write per cycle on port B; sweep takes exactly LINES cycles; counter SHALL NOT wrap past LINES-1.
REQ-021 flush_done SHALL pulse in the cycle after the final write of a FLUSH sweep; it SHALL NOT pulse for INIT.
REQ-022 flush_req asserted during INIT or FLUSH SHALL be latched and start one further FLUSH immediately after the current sweep.
REQ-023 lookup_ready = (state == IDLE); lookup accepted when lookup_req & lookup_ready.
REQ-024 Lookup latency: result_valid and hit SHALL be valid exactly 1 cycle after acceptance; fully pipelined, one lookup per cycle.
REQ-025 Port B priority in IDLE: fill > inv; fill_ack = fill_req & IDLE; inv_ack = inv_req & ~fill_req & IDLE.
REQ-026 In INIT/FLUSH, fill_ack and inv_ack SHALL be 0; requesters hold requests until acked.
REQ-027 Same-cycle collision: lookup accepted on line L while port B writes L -> result SHALL reflect the newly written entry (bypass register), never stale bank data.
REQ-028 Lookup accepted in the last IDLE cycle before FLUSH entry SHALL still produce its result next cycle.
REQ-029 hit SHALL be 0 whenever result_valid=0.

Reset
REQ-030 On rst: state=INIT, sweep counter=0, pending flush=0, result_valid=0, hit=0, flush_done=0, fill_ack=0, inv_ack=0, lookup_ready=0, busy=1.
REQ-031 rst asserted mid-sweep or mid-lookup SHALL abort it; the INIT sweep restarts from line 0 after release.
REQ-032 Tag bank contents SHALL be treated as unknown after rst until INIT completes.

Structure
REQ-033 Shared package SHALL hold the tag entry typedef (valid + tag) and the FSM state enum.
REQ-034 Exactly one sub-module instance: tag_bank, WIDTH = TAG_W+1, LINES = LINES.
REQ-035 Target size 120-400 lines RTL; no additional memories.

Verification
REQ-036 Reset release, LINES=16: busy=1 for 16 cycles, lookup_ready=0, no flush_done; then lookup any line -> hit=0.
REQ-037 Fill line 5 tag 0x1234, then lookup line 5 tag 0x1234 -> result_valid next cycle, hit=1; tag 0x1235 -> hit=0.
REQ-038 Same cycle fill line 7 tag 0xAA and inv line 7 -> fill_ack=1, inv_ack=0; next cycle inv_ack=1; lookup tag 0xAA -> hit=0.
REQ-039 Lookup line 3 tag 0x55 in same cycle as fill line 3 tag 0x55 -> hit=1 (bypass).
REQ-040 Fill lines 0..15, flush_req pulse, second flush_req during sweep -> two sweeps of 16 cycles, two flush_done pulses, all lookups hit=0 after.
REQ-041 rst asserted at sweep line 8 -> after release full 16-cycle INIT from line 0, pending flush cleared.
